// File: rtl/mem_latency_model.sv
// Multi-port memory model with cycle-counted read/write latency.
// A round-robin arbiter hands the single array to one requester at a time.
`timescale 1ns/1ps

module mem_latency_model #(
    parameter int MEM_ADDR_SIZE  = 8,
    parameter int MEM_WORD_SIZE  = 8,
    parameter int MEM_WR_LATENCY = 2,
    parameter int MEM_RD_LATENCY = 2,
    parameter int NUM_PORTS      = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_PORTS-1:0]               memReq,
    input  logic [NUM_PORTS-1:0]               memWr,
    input  logic [NUM_PORTS*MEM_ADDR_SIZE-1:0] memAddr,
    input  logic [NUM_PORTS*MEM_WORD_SIZE-1:0] memDataIn,
    output logic [NUM_PORTS-1:0]               memGrant,
    output logic [NUM_PORTS-1:0]               memDone,
    output logic                               memBusyOut,
    output logic [MEM_WORD_SIZE-1:0]           memDataOut
);

    localparam int DEPTH   = 1 << MEM_ADDR_SIZE;
    localparam int WR_LAT  = (MEM_WR_LATENCY < 1) ? 1 : MEM_WR_LATENCY;
    localparam int RD_LAT  = (MEM_RD_LATENCY < 1) ? 1 : MEM_RD_LATENCY;
    localparam int MAX_LAT = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]           port_q, port_d;
    logic [MEM_ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [MEM_WORD_SIZE-1:0]   data_q, data_d;
    logic                       wr_q, wr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]       grant_q, grant_d;
    logic [NUM_PORTS-1:0]       done_q, done_d;
    logic                       busy_q, busy_d;
    logic [MEM_WORD_SIZE-1:0]   dout_q, dout_d;

    logic                       mem_we;
    logic                       sel_found;
    logic [PTR_W-1:0]           sel_port;
    logic [PTR_W-1:0]           cand;

    logic [MEM_WORD_SIZE-1:0]   mem [DEPTH];

    // Round-robin search starting one past the last granted port.
    always_comb begin
        sel_found = 1'b0;
        sel_port  = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
            if (!sel_found && memReq[cand]) begin
                sel_found = 1'b1;
                sel_port  = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        port_d   = port_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        grant_d  = '0;
        done_d   = '0;
        busy_d   = busy_q;
        dout_d   = dout_q;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d           = ST_BUSY;
                    rr_ptr_d          = sel_port;
                    port_d            = sel_port;
                    addr_d            = memAddr[int'(sel_port)*MEM_ADDR_SIZE +: MEM_ADDR_SIZE];
                    data_d            = memDataIn[int'(sel_port)*MEM_WORD_SIZE +: MEM_WORD_SIZE];
                    wr_d              = memWr[sel_port];
                    cnt_d             = memWr[sel_port] ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
                    grant_d[sel_port] = 1'b1;
                    busy_d            = 1'b1;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Gating on reset keeps an aborted write out of the array.
                    if (wr_q) begin
                        mem_we = !reset;
                    end else begin
                        dout_d = mem[addr_q];
                    end
                    busy_d         = 1'b0;
                    done_d[port_q] = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= PTR_W'(NUM_PORTS - 1);
            port_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            port_q   <= port_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    assign memGrant   = grant_q;
    assign memDone    = done_q;
    assign memBusyOut = busy_q;
    assign memDataOut = dout_q;

endmodule

// File: tb/tb_mem_latency_model.sv
// Random + directed bench for mem_latency_model: a transaction-level model
// predicts grants and completions into queues, a negedge monitor checks them.
`timescale 1ns/1ps

module tb_mem_latency_model;

    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int NP     = 2;
    localparam int WR_EFF = 2;
    localparam int RD_EFF = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [NP-1:0]       req_v;
    logic [NP-1:0]       wr_v;
    logic [AW-1:0]       addr_v [NP];
    logic [DW-1:0]       data_v [NP];
    logic [NP*AW-1:0]    memAddr;
    logic [NP*DW-1:0]    memDataIn;
    logic [NP-1:0]       memGrant;
    logic [NP-1:0]       memDone;
    logic                memBusyOut;
    logic [DW-1:0]       memDataOut;

    always_comb begin
        memAddr   = '0;
        memDataIn = '0;
        for (int p = 0; p < NP; p++) begin
            memAddr[p*AW +: AW]   = addr_v[p];
            memDataIn[p*DW +: DW] = data_v[p];
        end
    end

    mem_latency_model #(
        .MEM_ADDR_SIZE (AW),
        .MEM_WORD_SIZE (DW),
        .MEM_WR_LATENCY(2),
        .MEM_RD_LATENCY(2),
        .NUM_PORTS     (NP)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .memReq    (req_v),
        .memWr     (wr_v),
        .memAddr   (memAddr),
        .memDataIn (memDataIn),
        .memGrant  (memGrant),
        .memDone   (memDone),
        .memBusyOut(memBusyOut),
        .memDataOut(memDataOut)
    );

    // Single-port instance with an asymmetric, clamped latency pair.
    logic          req2, wr2, grant2, done2, busy2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] data2, dout2;

    mem_latency_model #(
        .MEM_ADDR_SIZE (AW),
        .MEM_WORD_SIZE (DW),
        .MEM_WR_LATENCY(0),
        .MEM_RD_LATENCY(4),
        .NUM_PORTS     (1)
    ) u_dut_lat (
        .clk       (clk),
        .reset     (reset),
        .memReq    (req2),
        .memWr     (wr2),
        .memAddr   (addr2),
        .memDataIn (data2),
        .memGrant  (grant2),
        .memDone   (done2),
        .memBusyOut(busy2),
        .memDataOut(dout2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic bit bit_of(input logic [NP-1:0] v, input int k);
        logic [NP-1:0] s;
        s = v >> k;
        return s[0];
    endfunction

    function automatic int rr_pick(input logic [NP-1:0] r, input int last);
        for (int i = 1; i <= NP; i++) begin
            if (bit_of(r, (last + i) % NP)) return (last + i) % NP;
        end
        return -1;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int cyc;
        int port;
    } gnt_t;

    typedef struct {
        int            cyc;
        int            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    gnt_t gnt_q  [$];
    txn_t done_q [$];
    int   g_base  = 0;
    int   d_base  = 0;
    int   cyc     = 0;
    int   m_next  = 0;
    int   m_last  = NP - 1;
    int   b_start = 0;
    int   b_end   = 0;
    int   mp, mlat;

    // One grant per free slot; a transaction of latency L occupies L+2 cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            g_base  = gnt_q.size();
            d_base  = done_q.size();
            m_next  = cyc + 1;
            m_last  = NP - 1;
            b_start = 0;
            b_end   = 0;
        end else begin
            cyc = cyc + 1;
            if (cyc >= m_next && req_v != '0) begin
                mp   = rr_pick(req_v, m_last);
                mlat = bit_of(wr_v, mp) ? WR_EFF : RD_EFF;
                gnt_q.push_back('{cyc, mp});
                done_q.push_back('{cyc + mlat, mp, bit_of(wr_v, mp), addr_v[mp], data_v[mp]});
                b_start = cyc;
                b_end   = cyc + mlat;
                m_next  = cyc + mlat + 2;
                m_last  = mp;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [DW-1:0] m_mem   [1 << AW];
    bit            m_valid [1 << AW];
    logic [DW-1:0] exp_dout   = '0;
    bit            dout_known = 1'b1;
    bit            mon_en     = 1'b0;
    int            g_rd = 0;
    int            d_rd = 0;

    always @(negedge clk) begin : monitor
        logic [NP-1:0] eg, ed;
        txn_t          t;
        if (reset) begin
            g_rd       = g_base;
            d_rd       = d_base;
            exp_dout   = '0;
            dout_known = 1'b1;
        end else if (mon_en) begin
            eg = '0;
            ed = '0;
            if (g_rd < gnt_q.size() && gnt_q[g_rd].cyc == cyc) begin
                eg   = NP'(1) << gnt_q[g_rd].port;
                g_rd = g_rd + 1;
            end
            chk("grant", 32'(memGrant), 32'(eg));
            if (d_rd < done_q.size() && done_q[d_rd].cyc == cyc) begin
                t    = done_q[d_rd];
                ed   = NP'(1) << t.port;
                d_rd = d_rd + 1;
                if (t.wr) begin
                    m_mem[t.addr]   = t.data;
                    m_valid[t.addr] = 1'b1;
                end else begin
                    exp_dout   = m_mem[t.addr];
                    dout_known = m_valid[t.addr];
                end
            end
            chk("done", 32'(memDone), 32'(ed));
            chk("busy", 32'(memBusyOut), 32'(cyc >= b_start && cyc < b_end));
            if (dout_known) chk("dout", 32'(memDataOut), 32'(exp_dout));
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_op(input int p);
        wr_v      = (wr_v & ~(NP'(1) << p)) | (NP'($urandom_range(1)) << p);
        addr_v[p] = AW'($urandom_range(15));
        data_v[p] = DW'($urandom);
    endtask

    task automatic issue(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit scramble, output int lat, output logic [DW-1:0] rd);
        int n;
        req_v     = req_v | (NP'(1) << p);
        wr_v      = (wr_v & ~(NP'(1) << p)) | (NP'(wr) << p);
        addr_v[p] = a;
        data_v[p] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bit_of(memGrant, p) && n < 40);
        req_v = req_v & ~(NP'(1) << p);
        chk("grant_seen", 32'(bit_of(memGrant, p)), 32'd1);
        if (scramble) begin
            addr_v[p] = a ^ 8'h01;
            data_v[p] = ~d;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bit_of(memDone, p) && lat < 40);
        rd = memDataOut;
        @(negedge clk);
    endtask

    task automatic issue2(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output logic [DW-1:0] rd);
        int n;
        req2 = 1'b1; wr2 = wr; addr2 = a; data2 = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!grant2 && n < 40);
        req2 = 1'b0;
        chk("lat2_grant", 32'(grant2), 32'd1);
        chk("lat2_busy", 32'(busy2), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done2 && lat < 40);
        rd = dout2;
        @(negedge clk);
    endtask

    initial begin
        int            lat, ng, prev_p, prev_c, n;
        logic [DW-1:0] rd;

        reset = 1'b0;
        req_v = '0;
        wr_v  = '0;
        for (int p = 0; p < NP; p++) begin
            addr_v[p] = '0;
            data_v[p] = '0;
        end
        req2 = 1'b0; wr2 = 1'b0; addr2 = '0; data2 = '0;

        #1 reset = 1'b1;
        #1;
        chk("rst_grant", 32'(memGrant), 32'd0);
        chk("rst_done", 32'(memDone), 32'd0);
        chk("rst_busy", 32'(memBusyOut), 32'd0);
        chk("rst_dout", 32'(memDataOut), 32'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Both ports hammer the array: grants must alternate every L+2 cycles.
        req_v = '1;
        wr_v  = '1;
        for (int p = 0; p < NP; p++) begin
            addr_v[p] = AW'(p * 8);
            data_v[p] = DW'($urandom);
        end
        ng = 0; prev_p = -1; prev_c = 0;
        for (int i = 0; i < 80 && ng < 6; i++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (bit_of(memGrant, p)) begin
                    if (ng == 0) begin
                        chk("cont_first", 32'(p), 32'd0);
                    end else begin
                        chk("cont_alt", 32'(p), 32'(1 - prev_p));
                        chk("cont_gap", 32'(cyc - prev_c), 32'(WR_EFF + 2));
                    end
                    prev_p = p;
                    prev_c = cyc;
                    ng++;
                    addr_v[p] = addr_v[p] + 8'd1;
                    data_v[p] = DW'($urandom);
                end
            end
        end
        chk("cont_count", 32'(ng), 32'd6);
        req_v = '0;
        repeat (8) @(negedge clk);

        issue(0, 1'b1, 8'h10, 8'hA5, 1'b0, lat, rd);
        chk("wr_lat", 32'(lat), 32'(WR_EFF));
        issue(0, 1'b0, 8'h10, 8'h00, 1'b0, lat, rd);
        chk("rd_lat", 32'(lat), 32'(RD_EFF));
        chk("rd_data", 32'(rd), 32'hA5);

        issue(1, 1'b1, 8'h3C, 8'h5A, 1'b0, lat, rd);
        issue(1, 1'b0, 8'h3C, 8'h00, 1'b0, lat, rd);
        chk("hold_rd", 32'(rd), 32'h5A);
        issue(0, 1'b1, 8'h00, 8'hFF, 1'b0, lat, rd);
        chk("hold_after_wr", 32'(memDataOut), 32'h5A);

        // Abort a write mid-flight with reset; the old word must survive.
        issue(0, 1'b1, 8'h20, 8'h11, 1'b0, lat, rd);
        req_v = 2'b01; wr_v = 2'b01; addr_v[0] = 8'h20; data_v[0] = 8'h77;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!memGrant[0] && n < 40);
        req_v = '0;
        chk("abort_grant", 32'(memGrant[0]), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_grant0", 32'(memGrant), 32'd0);
        chk("abort_busy0", 32'(memBusyOut), 32'd0);
        chk("abort_dout0", 32'(memDataOut), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(memDone), 32'd0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        issue(0, 1'b0, 8'h20, 8'h00, 1'b0, lat, rd);
        chk("abort_keep", 32'(rd), 32'h11);

        // Inputs altered during BUSY must not affect the latched operation.
        issue(0, 1'b1, 8'h45, 8'h99, 1'b0, lat, rd);
        issue(1, 1'b1, 8'h44, 8'hC3, 1'b1, lat, rd);
        issue(0, 1'b0, 8'h44, 8'h00, 1'b0, lat, rd);
        chk("latch_data", 32'(rd), 32'hC3);
        issue(1, 1'b0, 8'h45, 8'h00, 1'b0, lat, rd);
        chk("latch_addr", 32'(rd), 32'h99);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (bit_of(memGrant, p)) begin
                    if ($urandom_range(3) != 0) rand_op(p);
                    else req_v = req_v & ~(NP'(1) << p);
                end else if (!bit_of(req_v, p) && $urandom_range(2) == 0) begin
                    req_v = req_v | (NP'(1) << p);
                    rand_op(p);
                end
            end
        end
        req_v = '0;
        repeat (10) @(negedge clk);

        issue2(1'b1, 8'h05, 8'h3E, lat, rd);
        chk("lat2_wr", 32'(lat), 32'd1);
        issue2(1'b0, 8'h05, 8'h00, lat, rd);
        chk("lat2_rd", 32'(lat), 32'd4);
        chk("lat2_data", 32'(rd), 32'h3E);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
